// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes,
// forwarding selections and the latched EX-stage record.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Everything captured from decode into the EX stage
    typedef struct packed {
        logic     valid;
        logic     regwen;
        regbits_t wsel;
        regbits_t rs;
        regbits_t rt;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        logic     alusrc;
        aluop_t   aluop;
    } ex_stage_t;

    // Pick the operand value named by a forwarding selection
    function automatic word_t fwd_mux(fwd_sel_t sel, word_t latched,
                                      word_t exmem, word_t memwb);
        word_t val;
        case (sel)
            FWD_EXMEM: val = exmem;
            FWD_MEMWB: val = memwb;
            default:   val = latched;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational forwarding selection for one source operand.
// EX/MEM (youngest) beats MEM/WB; register 0 is never forwarded.
module forwarding_unit
    import cpu_types_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic     valid_i,
    input  regbits_t src_i,
    input  logic     exmem_regwen_i,
    input  regbits_t exmem_wsel_i,
    input  logic     memwb_regwen_i,
    input  regbits_t memwb_wsel_i,
    output fwd_sel_t sel_o
);

    // Priority match against the two in-flight producers
    always_comb begin
        sel_o = FWD_NONE;
        if (FWD_EN != 0 && valid_i && src_i != '0) begin
            if (exmem_regwen_i && exmem_wsel_i == src_i) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_regwen_i && memwb_wsel_i == src_i) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/ex_operand_latch.sv
// ID/EX pipeline register with operand forwarding: latches decode
// fields, then resolves ALU operands against EX/MEM and MEM/WB producers.
module ex_operand_latch
    import cpu_types_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     enable,
    input  logic     flush,
    input  logic     id_valid,
    input  word_t    id_rdat1,
    input  word_t    id_rdat2,
    input  word_t    id_imm,
    input  logic     id_alusrc,
    input  aluop_t   id_aluop,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  regbits_t id_wsel,
    input  logic     id_regwen,
    input  logic     exmem_regwen,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_result,
    input  logic     memwb_regwen,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_wdat,
    output word_t    porta,
    output word_t    portb,
    output aluop_t   aluop,
    output word_t    ex_rdat2,
    output logic     ex_valid,
    output logic     ex_regwen,
    output regbits_t ex_wsel,
    output fwd_sel_t fwd_a,
    output fwd_sel_t fwd_b
);

    ex_stage_t stage_d, stage_q;
    word_t     rs_val, rt_val;

    // Next stage contents: flush beats enable, otherwise hold
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (enable) begin
            stage_d.valid  = id_valid;
            stage_d.regwen = id_regwen & id_valid;
            stage_d.wsel   = id_wsel;
            stage_d.rs     = id_rs;
            stage_d.rt     = id_rt;
            stage_d.rdat1  = id_rdat1;
            stage_d.rdat2  = id_rdat2;
            stage_d.imm    = id_imm;
            stage_d.alusrc = id_alusrc;
            stage_d.aluop  = id_aluop;
        end
    end

    // Stage register, asynchronously cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    forwarding_unit #(.FWD_EN(FWD_EN)) u_fwd_a (
        .valid_i        (stage_q.valid),
        .src_i          (stage_q.rs),
        .exmem_regwen_i (exmem_regwen),
        .exmem_wsel_i   (exmem_wsel),
        .memwb_regwen_i (memwb_regwen),
        .memwb_wsel_i   (memwb_wsel),
        .sel_o          (fwd_a)
    );

    forwarding_unit #(.FWD_EN(FWD_EN)) u_fwd_b (
        .valid_i        (stage_q.valid),
        .src_i          (stage_q.rt),
        .exmem_regwen_i (exmem_regwen),
        .exmem_wsel_i   (exmem_wsel),
        .memwb_regwen_i (memwb_regwen),
        .memwb_wsel_i   (memwb_wsel),
        .sel_o          (fwd_b)
    );

    // Operand resolution; forwarding re-evaluates every cycle, even while held
    always_comb begin
        rs_val    = fwd_mux(fwd_a, stage_q.rdat1, exmem_result, memwb_wdat);
        rt_val    = fwd_mux(fwd_b, stage_q.rdat2, exmem_result, memwb_wdat);
        porta     = rs_val;
        portb     = stage_q.alusrc ? stage_q.imm : rt_val;
        ex_rdat2  = rt_val;
        aluop     = stage_q.aluop;
        ex_valid  = stage_q.valid;
        ex_regwen = stage_q.regwen;
        ex_wsel   = stage_q.wsel;
    end

endmodule

// File: tb/tb_ex_operand_latch.sv
// Directed bench for ex_operand_latch: table of single-edge vectors
// plus hand sequences for reset, stall-time forwarding and async reset.
module tb_ex_operand_latch;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST;
    logic     enable, flush, id_valid, id_alusrc, id_regwen;
    word_t    id_rdat1, id_rdat2, id_imm;
    aluop_t   id_aluop;
    regbits_t id_rs, id_rt, id_wsel;
    logic     exmem_regwen, memwb_regwen;
    regbits_t exmem_wsel, memwb_wsel;
    word_t    exmem_result, memwb_wdat;
    word_t    porta, portb, ex_rdat2;
    aluop_t   aluop;
    logic     ex_valid, ex_regwen;
    regbits_t ex_wsel;
    fwd_sel_t fwd_a, fwd_b;

    int tests = 0;
    int fails = 0;

    ex_operand_latch #(.FWD_EN(1)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
        .id_valid(id_valid), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel), .id_regwen(id_regwen),
        .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
        .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .porta(porta), .portb(portb), .aluop(aluop), .ex_rdat2(ex_rdat2),
        .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_wsel(ex_wsel),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic     en, fl, valid, alusrc, regwen;
        word_t    rdat1, rdat2, imm;
        aluop_t   op;
        regbits_t rs, rt, wsel;
        logic     xr, mr;
        regbits_t xw, mw;
        word_t    xd, md;
        word_t    e_porta, e_portb, e_rdat2;
        aluop_t   e_op;
        logic     e_valid, e_regwen;
        regbits_t e_wsel;
        fwd_sel_t e_fa, e_fb;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        enable = x.en;  flush = x.fl;  id_valid = x.valid;
        id_rdat1 = x.rdat1;  id_rdat2 = x.rdat2;  id_imm = x.imm;
        id_alusrc = x.alusrc;  id_aluop = x.op;
        id_rs = x.rs;  id_rt = x.rt;  id_wsel = x.wsel;  id_regwen = x.regwen;
        exmem_regwen = x.xr;  exmem_wsel = x.xw;  exmem_result = x.xd;
        memwb_regwen = x.mr;  memwb_wsel = x.mw;  memwb_wdat = x.md;
    endtask

    task automatic check_all(input string p, input vec_t x);
        chk({p, ".porta"},  porta,     x.e_porta);
        chk({p, ".portb"},  portb,     x.e_portb);
        chk({p, ".rdat2"},  ex_rdat2,  x.e_rdat2);
        chk({p, ".aluop"},  32'(aluop), 32'(x.e_op));
        chk({p, ".valid"},  32'(ex_valid),  32'(x.e_valid));
        chk({p, ".regwen"}, 32'(ex_regwen), 32'(x.e_regwen));
        chk({p, ".wsel"},   32'(ex_wsel),   32'(x.e_wsel));
        chk({p, ".fwd_a"},  32'(fwd_a), 32'(x.e_fa));
        chk({p, ".fwd_b"},  32'(fwd_b), 32'(x.e_fb));
    endtask

    initial begin
        vec_t z;
        z = '{default: '0, op: ALU_SLL, e_op: ALU_SLL, e_fa: FWD_NONE, e_fb: FWD_NONE};

        // 0: plain pass-through, no producers
        v = z; v.en = 1; v.valid = 1; v.regwen = 1; v.op = ALU_ADD;
        v.rdat1 = 32'h10; v.rdat2 = 32'h20; v.rs = 1; v.rt = 2; v.wsel = 3;
        v.e_porta = 32'h10; v.e_portb = 32'h20; v.e_rdat2 = 32'h20; v.e_op = ALU_ADD;
        v.e_valid = 1; v.e_regwen = 1; v.e_wsel = 3;
        vecs.push_back(v);
        // 1: double hazard on rs, EX/MEM wins
        v = z; v.en = 1; v.valid = 1; v.op = ALU_SUB; v.rs = 5; v.rt = 6; v.wsel = 7;
        v.rdat1 = 32'h1; v.rdat2 = 32'h2;
        v.xr = 1; v.xw = 5; v.xd = 32'hAAAA; v.mr = 1; v.mw = 5; v.md = 32'hBBBB;
        v.e_porta = 32'hAAAA; v.e_portb = 32'h2; v.e_rdat2 = 32'h2; v.e_op = ALU_SUB;
        v.e_valid = 1; v.e_wsel = 7; v.e_fa = FWD_EXMEM;
        vecs.push_back(v);
        // 2: immediate operand plus forwarded store data
        v = z; v.en = 1; v.valid = 1; v.alusrc = 1; v.op = ALU_ADD; v.imm = 32'hFFFFFFFC;
        v.rs = 4; v.rt = 3; v.rdat1 = 32'h44; v.rdat2 = 32'h33;
        v.xr = 0; v.xw = 3; v.xd = 32'h99; v.mr = 1; v.mw = 3; v.md = 32'h77;
        v.e_porta = 32'h44; v.e_portb = 32'hFFFFFFFC; v.e_rdat2 = 32'h77; v.e_op = ALU_ADD;
        v.e_valid = 1; v.e_fb = FWD_MEMWB;
        vecs.push_back(v);
        // 3: register 0 is never forwarded
        v = z; v.en = 1; v.valid = 1; v.op = ALU_AND; v.rdat1 = 32'h5; v.rdat2 = 32'h6;
        v.xr = 1; v.xw = 0; v.xd = 32'hDEAD; v.mr = 1; v.mw = 0; v.md = 32'hBEEF;
        v.e_porta = 32'h5; v.e_portb = 32'h6; v.e_rdat2 = 32'h6; v.e_op = ALU_AND; v.e_valid = 1;
        vecs.push_back(v);
        // 4: bubble from decode: no regwen, no forwarding
        v = z; v.en = 1; v.valid = 0; v.regwen = 1; v.op = ALU_XOR; v.rs = 7; v.rt = 8; v.wsel = 4;
        v.rdat1 = 32'h70; v.rdat2 = 32'h71; v.xr = 1; v.xw = 7; v.xd = 32'h1234;
        v.mr = 1; v.mw = 8; v.md = 32'h5678;
        v.e_porta = 32'h70; v.e_portb = 32'h71; v.e_rdat2 = 32'h71; v.e_op = ALU_XOR; v.e_wsel = 4;
        vecs.push_back(v);
        // 5: flush and enable together: flush wins, everything cleared
        v = z; v.en = 1; v.fl = 1; v.valid = 1; v.regwen = 1; v.op = ALU_NOR; v.rs = 2; v.rt = 2;
        v.wsel = 9; v.rdat1 = 32'h55; v.rdat2 = 32'h66; v.imm = 32'h7; v.alusrc = 1;
        v.xr = 1; v.xw = 2; v.xd = 32'hCC;
        vecs.push_back(v);
        // 6: both operands forwarded from different stages
        v = z; v.en = 1; v.valid = 1; v.regwen = 1; v.op = ALU_OR; v.rs = 8; v.rt = 9; v.wsel = 12;
        v.rdat1 = 32'h81; v.rdat2 = 32'h91;
        v.xr = 1; v.xw = 9; v.xd = 32'hCAFE; v.mr = 1; v.mw = 8; v.md = 32'hBEEF;
        v.e_porta = 32'hBEEF; v.e_portb = 32'hCAFE; v.e_rdat2 = 32'hCAFE; v.e_op = ALU_OR;
        v.e_valid = 1; v.e_regwen = 1; v.e_wsel = 12; v.e_fa = FWD_MEMWB; v.e_fb = FWD_EXMEM;
        vecs.push_back(v);
        // 7: hold with new decode fields; producers gone, latched values show
        v = z; v.en = 0; v.valid = 1; v.regwen = 0; v.op = ALU_SLT; v.rs = 1; v.rt = 1; v.wsel = 1;
        v.rdat1 = 32'hF1; v.rdat2 = 32'hF2; v.alusrc = 1; v.imm = 32'hF3;
        v.e_porta = 32'h81; v.e_portb = 32'h91; v.e_rdat2 = 32'h91; v.e_op = ALU_OR;
        v.e_valid = 1; v.e_regwen = 1; v.e_wsel = 12;
        vecs.push_back(v);

        // Reset held for two cycles with busy inputs
        RST = 1'b1;
        v = vecs[6]; drive(v);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.porta", porta, '0);
        chk("rst.portb", portb, '0);
        chk("rst.rdat2", ex_rdat2, '0);
        chk("rst.aluop", 32'(aluop), 32'(ALU_SLL));
        chk("rst.valid", 32'(ex_valid), 0);
        chk("rst.regwen", 32'(ex_regwen), 0);
        chk("rst.wsel", 32'(ex_wsel), 0);
        chk("rst.fwd_a", 32'(fwd_a), 32'(FWD_NONE));
        chk("rst.fwd_b", 32'(fwd_b), 32'(FWD_NONE));
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            @(posedge CLK);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Stall: load, then hold for three cycles with a producer only in cycle 2
        @(negedge CLK);
        v = z; v.en = 1; v.valid = 1; v.regwen = 1; v.op = ALU_SRL; v.rs = 10; v.rt = 11; v.wsel = 13;
        v.rdat1 = 32'h100; v.rdat2 = 32'h200;
        drive(v);
        @(posedge CLK); #1;
        chk("ld.porta", porta, 32'h100);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            enable = 1'b0;
            id_rs = regbits_t'(c); id_rt = regbits_t'(c); id_rdat1 = 32'(c); id_rdat2 = 32'(c);
            id_aluop = ALU_SLTU; id_valid = 1'b0; id_wsel = 5'd1;
            exmem_regwen = (c == 2); exmem_wsel = 5'd10; exmem_result = 32'h5555;
            @(posedge CLK); #1;
            chk($sformatf("st%0d.porta", c), porta, (c == 2) ? 32'h5555 : 32'h100);
            chk($sformatf("st%0d.fwd_a", c), 32'(fwd_a), (c == 2) ? 32'(FWD_EXMEM) : 32'(FWD_NONE));
            chk($sformatf("st%0d.portb", c), portb, 32'h200);
            chk($sformatf("st%0d.aluop", c), 32'(aluop), 32'(ALU_SRL));
            chk($sformatf("st%0d.valid", c), 32'(ex_valid), 1);
            chk($sformatf("st%0d.wsel", c), 32'(ex_wsel), 13);
        end

        // Asynchronous reset mid-stall, no clock edge needed
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("arst.valid", 32'(ex_valid), 0);
        chk("arst.regwen", 32'(ex_regwen), 0);
        chk("arst.porta", porta, '0);
        chk("arst.portb", portb, '0);
        chk("arst.wsel", 32'(ex_wsel), 0);
        // Reset also dominates a flush/enable edge
        enable = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        chk("arst2.valid", 32'(ex_valid), 0);
        // First edge after release behaves normally
        @(negedge CLK);
        RST = 1'b0;
        drive(vecs[0]);
        @(posedge CLK); #1;
        check_all("post", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
